// File: rtl/serial_input.sv
// UART 8N1 receiver: oversamples the asynchronous rx line and presents each
// received byte as a 32-bit word on a stb/ack stream, with error pulses.
module serial_input #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] output_rs232_rx,
  output logic        output_rs232_rx_stb,
  input  logic        output_rs232_rx_ack,
  output logic        framing_error,
  output logic        overrun,
  output logic [2:0]  state_dbg
);

  localparam int DIVIDER = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF    = DIVIDER / 2;
  localparam int CW      = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIVIDER - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  // Stream handshake: a word moves on every rising edge where stb && ack;
  // the word is held stable while stb is high and no transfer happens.

  logic          rx_m;
  logic          rx_s;
  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [2:0]    bit_index;
  logic [2:0]    bit_next;
  logic [7:0]    shift;
  logic [7:0]    shift_next;
  logic          deliver;
  logic          frame_bad;
  logic          transfer;
  logic          load;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      bit_index <= 3'd0;
      shift     <= 8'd0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      bit_index <= bit_next;
      shift     <= shift_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count + 1'b1;
    bit_next   = bit_index;
    shift_next = shift;
    deliver    = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      S_IDLE: begin
        count_next = '0;
        if (!rx_s) state_next = S_START;
      end
      S_START: begin
        if (count == HALF_LAST) begin
          count_next = '0;
          if (!rx_s) begin
            bit_next   = 3'd0;
            state_next = S_DATA;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (count == DIV_LAST) begin
          count_next = '0;
          // LSB arrives first, so shift right and insert at the top.
          shift_next = {rx_s, shift[7:1]};
          bit_next   = bit_index + 3'd1;
          if (bit_index == 3'd7) state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (count == DIV_LAST) begin
          count_next = '0;
          if (rx_s) begin
            deliver    = 1'b1;
            state_next = S_IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_next = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        count_next = '0;
        if (rx_s) state_next = S_IDLE;
      end
      default: begin
        count_next = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  assign transfer = output_rs232_rx_stb && output_rs232_rx_ack;
  // A new byte may replace the pending word only if that word leaves this edge.
  assign load     = deliver && (!output_rs232_rx_stb || output_rs232_rx_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      output_rs232_rx     <= 32'd0;
      output_rs232_rx_stb <= 1'b0;
      framing_error       <= 1'b0;
      overrun             <= 1'b0;
    end else begin
      framing_error <= frame_bad;
      overrun       <= deliver && !load;
      if (load) begin
        output_rs232_rx     <= {24'd0, shift};
        output_rs232_rx_stb <= 1'b1;
      end else if (transfer) begin
        output_rs232_rx_stb <= 1'b0;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_serial_input.sv
// Bench for serial_input: vector table, hand-written corner sequences and
// randomized frames checked against a queue-based reference model.
module tb_serial_input;

  localparam int CLK_F = 1000000;
  localparam int BAUD  = 100000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        ack = 1'b0;
  logic [31:0] word;
  logic        stb;
  logic        fe;
  logic        ovr;
  logic [2:0]  state_dbg;

  serial_input #(.CLOCK_FREQUENCY(CLK_F), .BAUD_RATE(BAUD)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rx                  (rx),
    .output_rs232_rx     (word),
    .output_rs232_rx_stb (stb),
    .output_rs232_rx_ack (ack),
    .framing_error       (fe),
    .overrun             (ovr),
    .state_dbg           (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: records transfers and pulses a little after each falling edge
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int fe_cnt = 0;
  int ovr_cnt = 0;
  int stb_hi_cnt = 0;
  int last_rise = -1;
  logic stb_prev = 1'b0;
  int t0 = 0;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (stb && ack) got_q.push_back(word);
        if (fe) fe_cnt++;
        if (ovr) ovr_cnt++;
        if (stb) stb_hi_cnt++;
        if (stb && !stb_prev) last_rise = cyc;
      end
      stb_prev = stb;
    end
  end

  // scoreboard
  int tests = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_got(input string name, input logic [31:0] exp);
    tests++;
    if (got_q.size() == 0) begin
      failures++;
      $display("FAIL %s: no word delivered, expected 0x%08h", name, exp);
    end else begin
      logic [31:0] g;
      g = got_q.pop_front();
      if (g !== exp) begin
        failures++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h", name, g, exp);
      end
    end
  endtask

  // drivers
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] data, input logic stop_bit,
                           input int ack_j, input int rst_j);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (j == 0) t0 = cyc;
      rx = bits[j / 10];
      if (ack_j >= 0 && j == ack_j) ack = 1'b1;
      else if (ack_j >= 0 && j == ack_j + 1) ack = 1'b0;
      if (rst_j >= 0 && j == rst_j) rst = 1'b1;
      else if (rst_j >= 0 && j == rst_j + 1) rst = 1'b0;
    end
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic [31:0] exp_word;
    logic        exp_fe;
  } vec_t;

  vec_t vec[6];

  initial begin
    int fe_base;
    int ovr_base;
    int hi_base;
    int lat;
    int exp_fe_cnt;

    vec[0] = '{8'h01, 1'b1, 32'h0000_0001, 1'b0};
    vec[1] = '{8'h80, 1'b1, 32'h0000_0080, 1'b0};
    vec[2] = '{8'hC3, 1'b0, 32'h0000_0000, 1'b1};
    vec[3] = '{8'h7F, 1'b1, 32'h0000_007F, 1'b0};
    vec[4] = '{8'hAA, 1'b1, 32'h0000_00AA, 1'b0};
    vec[5] = '{8'h00, 1'b0, 32'h0000_0000, 1'b1};

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_word", word, 32'd0);
    check("reset_stb", {31'd0, stb}, 32'd0);
    check("reset_fe", {31'd0, fe}, 32'd0);
    check("reset_ovr", {31'd0, ovr}, 32'd0);
    check("reset_state", {29'd0, state_dbg}, 32'd0);

    // basic receive with ack low: latency, hold, single-cycle ack
    ack = 1'b0;
    idle(5);
    send_byte(8'hA5, 1'b1, -1, -1);
    idle(20);
    lat = last_rise - t0;
    tests++;
    if (lat < 97 || lat > 99) begin
      failures++;
      $display("FAIL basic_latency: got %0d cycles, expected 98 (+/-1)", lat);
    end
    check("basic_word", word, 32'h0000_00A5);
    check("basic_stb_held", {31'd0, stb}, 32'd1);
    ack_pulse();
    check("basic_stb_clear", {31'd0, stb}, 32'd0);
    expect_got("basic_transfer", 32'h0000_00A5);

    // back-to-back with ack tied high
    got_q.delete();
    ack = 1'b1;
    fe_base = fe_cnt; ovr_base = ovr_cnt; hi_base = stb_hi_cnt;
    send_byte(8'h00, 1'b1, -1, -1);
    send_byte(8'hFF, 1'b1, -1, -1);
    send_byte(8'h55, 1'b1, -1, -1);
    idle(10);
    expect_got("b2b_0", 32'h0000_0000);
    expect_got("b2b_1", 32'h0000_00FF);
    expect_got("b2b_2", 32'h0000_0055);
    check("b2b_stb_cycles", stb_hi_cnt - hi_base, 3);
    check("b2b_ovr", ovr_cnt - ovr_base, 0);
    check("b2b_fe", fe_cnt - fe_base, 0);

    // overrun: second byte dropped while first is pending
    got_q.delete();
    ack = 1'b0;
    ovr_base = ovr_cnt;
    send_byte(8'h12, 1'b1, -1, -1);
    send_byte(8'h34, 1'b1, -1, -1);
    idle(5);
    check("ovr_word_kept", word, 32'h0000_0012);
    check("ovr_stb", {31'd0, stb}, 32'd1);
    check("ovr_pulses", ovr_cnt - ovr_base, 1);
    ack_pulse();
    expect_got("ovr_transfer", 32'h0000_0012);
    check("ovr_stb_clear", {31'd0, stb}, 32'd0);

    // ack on the same edge as the next byte completes
    got_q.delete();
    ovr_base = ovr_cnt;
    send_byte(8'h12, 1'b1, -1, -1);
    send_byte(8'h34, 1'b1, 97, -1);
    idle(5);
    check("same_edge_stb", {31'd0, stb}, 32'd1);
    check("same_edge_word", word, 32'h0000_0034);
    check("same_edge_ovr", ovr_cnt - ovr_base, 0);
    expect_got("same_edge_old", 32'h0000_0012);
    ack_pulse();
    expect_got("same_edge_new", 32'h0000_0034);

    // framing error followed by a break
    got_q.delete();
    ack = 1'b1;
    fe_base = fe_cnt;
    send_byte(8'h3C, 1'b0, -1, -1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle(5);
    check("break_fe_once", fe_cnt - fe_base, 1);
    check("break_no_word", got_q.size(), 0);
    send_byte(8'h81, 1'b1, -1, -1);
    idle(5);
    expect_got("after_break", 32'h0000_0081);
    check("after_break_fe", fe_cnt - fe_base, 1);

    // short glitch is rejected
    got_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle(20);
    check("glitch_state", {29'd0, state_dbg}, 32'd0);
    check("glitch_no_word", got_q.size(), 0);
    check("glitch_stb", {31'd0, stb}, 32'd0);

    // reset mid-frame clears a pending word and discards the frame
    got_q.delete();
    ack = 1'b0;
    ovr_base = ovr_cnt;
    send_byte(8'h11, 1'b1, -1, -1);
    idle(3);
    check("pre_reset_stb", {31'd0, stb}, 32'd1);
    send_byte(8'hFF, 1'b1, -1, 40);
    idle(3);
    check("mid_reset_word", word, 32'd0);
    check("mid_reset_stb", {31'd0, stb}, 32'd0);
    check("mid_reset_state", {29'd0, state_dbg}, 32'd0);
    ack = 1'b1;
    send_byte(8'h7E, 1'b1, -1, -1);
    idle(5);
    expect_got("post_reset", 32'h0000_007E);
    check("post_reset_ovr", ovr_cnt - ovr_base, 0);

    // vector table
    got_q.delete();
    ack = 1'b1;
    for (int v = 0; v < 6; v++) begin
      fe_base = fe_cnt;
      send_byte(vec[v].data, vec[v].stop, -1, -1);
      idle(4);
      if (vec[v].exp_fe) begin
        check("vec_fe", fe_cnt - fe_base, 1);
        check("vec_fe_no_word", got_q.size(), 0);
      end else begin
        expect_got("vec_word", vec[v].exp_word);
        check("vec_no_fe", fe_cnt - fe_base, 0);
      end
    end

    // randomized frames against the reference model
    got_q.delete();
    exp_q.delete();
    ack = 1'b1;
    fe_base = fe_cnt;
    exp_fe_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      logic       s;
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 5) != 0);
      if (s) exp_q.push_back({24'd0, d});
      else exp_fe_cnt++;
      send_byte(d, s, -1, -1);
      if (s) idle($urandom_range(0, 3));
      else idle($urandom_range(2, 6));
    end
    idle(10);
    check("rand_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      expect_got("rand_word", exp_q.pop_front());
    check("rand_fe", fe_cnt - fe_base, exp_fe_cnt);

    // report
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
